// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong paddle datapath.
// PADDLE_DELTA_ACCUM_EN selects accumulate vs latest-packet-wins in paddle_pos_ctrl.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CLAMP
    } state_e;

    localparam int PEND_W       = 12;
    localparam int POS_W        = 10;
    localparam int SCREEN_H_DEF = 480;
    localparam int PADDLE_H_DEF = 64;
    localparam int Y_RESET_DEF  = (SCREEN_H_DEF - PADDLE_H_DEF) / 2;

    // Overflow reports pin the delta to the 9-bit extremes
    function automatic logic signed [PEND_W-1:0] delta_of(
        input logic       dir,
        input logic       max_spd,
        input logic [7:0] spd
    );
        logic [8:0] d9;
        if (max_spd)
            d9 = dir ? 9'h100 : 9'h0FF;
        else
            d9 = {dir, spd};
        return {{(PEND_W-9){d9[8]}}, d9};
    endfunction

endpackage

// File: rtl/sat_add_s12.sv
// 12-bit signed adder saturating at +2047 / -2048.
module sat_add_s12
    import pong_pkg::*;
(
    input  logic signed [PEND_W-1:0] a_i,
    input  logic signed [PEND_W-1:0] b_i,
    output logic signed [PEND_W-1:0] sum_o
);

    logic [PEND_W:0] full;

    always_comb begin
        full = {a_i[PEND_W-1], a_i} + {b_i[PEND_W-1], b_i};
        if (full[PEND_W] != full[PEND_W-1])
            sum_o = full[PEND_W] ? {1'b1, {(PEND_W-1){1'b0}}}
                                 : {1'b0, {(PEND_W-1){1'b1}}};
        else
            sum_o = full[PEND_W-1:0];
    end

endmodule

// File: rtl/paddle_pos_ctrl.sv
// Frame-synchronous paddle position from mouse Y reports.
// Define PADDLE_DELTA_ACCUM_EN to accumulate packets; otherwise latest wins.
module paddle_pos_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int PADDLE_H   = PADDLE_H_DEF,
    parameter int SENS_SHIFT = 0,
    parameter int Y_RESET    = Y_RESET_DEF
) (
    input  logic             clk_25MHz,
    input  logic             reset_n,
    input  logic             new_out,
    input  logic             y_dir,
    input  logic             y_max_speed,
    input  logic [7:0]       y_speed,
    input  logic             frame_tick,
    output logic [POS_W-1:0] paddle_y,
    output logic             update_done,
    output logic             frame_overrun
);

    localparam logic [POS_W-1:0] Y_MAX = POS_W'(SCREEN_H - PADDLE_H);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_RESET);

    state_e                    state_q, state_d;
    logic signed [PEND_W-1:0]  pend_q, pend_d;
    logic signed [PEND_W-1:0]  snap_q, snap_d;
    logic signed [PEND_W:0]    cand_q, cand_d;
    logic [POS_W-1:0]          paddle_y_q, paddle_y_d;
    logic                      update_done_q, update_done_d;
    logic                      frame_overrun_q, frame_overrun_d;

    logic signed [PEND_W-1:0]  delta;
    logic signed [PEND_W-1:0]  acc_base;
    logic signed [PEND_W-1:0]  acc_sum;
    logic signed [PEND_W-1:0]  mv;
    logic                      snap_now;

    assign delta    = delta_of(y_dir, y_max_speed, y_speed);
    assign snap_now = (state_q == ST_IDLE) && frame_tick;
    assign mv       = snap_q >>> SENS_SHIFT;

    // A packet landing on the snapshot cycle starts from an empty pend
`ifdef PADDLE_DELTA_ACCUM_EN
    assign acc_base = snap_now ? '0 : pend_q;
`else
    assign acc_base = '0;
`endif

    sat_add_s12 u_sat (
        .a_i   (acc_base),
        .b_i   (delta),
        .sum_o (acc_sum)
    );

    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        snap_d          = snap_q;
        cand_d          = cand_q;
        paddle_y_d      = paddle_y_q;
        update_done_d   = 1'b0;
        frame_overrun_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    snap_d  = pend_q;
                    pend_d  = '0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cand_d = $signed({3'b000, paddle_y_q})
                       - $signed({mv[PEND_W-1], mv});
                frame_overrun_d = frame_tick;
                state_d = ST_CLAMP;
            end
            ST_CLAMP: begin
                if (cand_q[PEND_W])
                    paddle_y_d = '0;
                else if (cand_q > $signed({3'b000, Y_MAX}))
                    paddle_y_d = Y_MAX;
                else
                    paddle_y_d = cand_q[POS_W-1:0];
                update_done_d   = 1'b1;
                frame_overrun_d = frame_tick;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_out)
            pend_d = acc_sum;
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            pend_q          <= '0;
            snap_q          <= '0;
            cand_q          <= '0;
            paddle_y_q      <= Y_RST;
            update_done_q   <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            snap_q          <= snap_d;
            cand_q          <= cand_d;
            paddle_y_q      <= paddle_y_d;
            update_done_q   <= update_done_d;
            frame_overrun_q <= frame_overrun_d;
        end
    end

    assign paddle_y      = paddle_y_q;
    assign update_done   = update_done_q;
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Directed bench for paddle_pos_ctrl with a cycle-level reference model.
// Honours PADDLE_DELTA_ACCUM_EN the same way as the design.
module tb_paddle_pos_ctrl;

    localparam int SH    = 0;
    localparam int Y_TOP = 480 - 64;

    logic       clk;
    logic       reset_n;
    logic       new_out;
    logic       y_dir;
    logic       y_max_speed;
    logic [7:0] y_speed;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       update_done;
    logic       frame_overrun;

    int checks;
    int errors;
    int done_cnt;
    int ovr_cnt;

    paddle_pos_ctrl #(
        .SCREEN_H   (480),
        .PADDLE_H   (64),
        .SENS_SHIFT (SH),
        .Y_RESET    (208)
    ) dut (
        .clk_25MHz     (clk),
        .reset_n       (reset_n),
        .new_out       (new_out),
        .y_dir         (y_dir),
        .y_max_speed   (y_max_speed),
        .y_speed       (y_speed),
        .frame_tick    (frame_tick),
        .paddle_y      (paddle_y),
        .update_done   (update_done),
        .frame_overrun (frame_overrun)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic int delta_m(input logic d, input logic m, input logic [7:0] s);
        if (m) return d ? -256 : 255;
        return d ? int'(s) - 256 : int'(s);
    endfunction

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int clampy(input int v);
        if (v < 0) return 0;
        if (v > Y_TOP) return Y_TOP;
        return v;
    endfunction

    // Reference model: pending movement, frame snapshot, countdown to commit
    int m_pend, m_snap, m_busy, exp_pos;
    bit exp_done, exp_ovr;

    always @(posedge clk or negedge reset_n) begin : model
        int base, nxt;
        if (!reset_n) begin
            m_pend   <= 0;
            m_snap   <= 0;
            m_busy   <= 0;
            exp_pos  <= 208;
            exp_done <= 1'b0;
            exp_ovr  <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            exp_ovr  <= 1'b0;
            base = m_pend;
            if (m_busy == 0) begin
                if (frame_tick) begin
                    m_snap <= m_pend;
                    m_busy <= 2;
                    base = 0;
                end
            end else begin
                if (frame_tick) exp_ovr <= 1'b1;
                if (m_busy == 1) begin
                    exp_pos  <= clampy(exp_pos - (m_snap >>> SH));
                    exp_done <= 1'b1;
                end
                m_busy <= m_busy - 1;
            end
`ifdef PADDLE_DELTA_ACCUM_EN
            nxt = sat12(base + delta_m(y_dir, y_max_speed, y_speed));
`else
            nxt = delta_m(y_dir, y_max_speed, y_speed);
`endif
            if (new_out) m_pend <= nxt;
            else if (base != m_pend) m_pend <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (int'(paddle_y) != exp_pos) begin
                errors++;
                $display("FAIL paddle_y t=%0t got %0d want %0d", $time, paddle_y, exp_pos);
            end
            checks++;
            if (update_done !== exp_done) begin
                errors++;
                $display("FAIL update_done t=%0t got %0b want %0b", $time, update_done, exp_done);
            end
            checks++;
            if (frame_overrun !== exp_ovr) begin
                errors++;
                $display("FAIL frame_overrun t=%0t got %0b want %0b", $time, frame_overrun, exp_ovr);
            end
            if (update_done === 1'b1) done_cnt++;
            if (frame_overrun === 1'b1) ovr_cnt++;
        end
    end

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wait_n(2);
        reset_n = 1'b1;
    endtask

    task automatic pkt(input logic d, input logic m, input logic [7:0] s);
        @(negedge clk);
        new_out = 1'b1;
        y_dir = d;
        y_max_speed = m;
        y_speed = s;
        @(negedge clk);
        new_out = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    int d0, o0;

    initial begin
        checks = 0; errors = 0; done_cnt = 0; ovr_cnt = 0;
        reset_n = 1'b0; new_out = 1'b0; y_dir = 1'b0;
        y_max_speed = 1'b0; y_speed = 8'h00; frame_tick = 1'b0;
        wait_n(3);
        reset_n = 1'b1;
        wait_n(1);
        lit("reset_pos", int'(paddle_y), 208);

        d0 = done_cnt;
        pkt(1'b0, 1'b0, 8'd10);
        tick();
        wait_n(4);
        lit("up_pos", int'(paddle_y), 198);
        lit("up_done_cnt", done_cnt - d0, 1);

        do_reset();
        pkt(1'b1, 1'b0, 8'hF6);
        tick();
        wait_n(4);
        lit("down_pos", int'(paddle_y), 218);

        do_reset();
        pkt(1'b1, 1'b1, 8'h00);
        tick();
        wait_n(4);
        lit("clamp_bottom", int'(paddle_y), 416);

        do_reset();
        pkt(1'b0, 1'b1, 8'h00);
        tick();
        wait_n(4);
        lit("clamp_top", int'(paddle_y), 0);

        d0 = done_cnt;
        tick();
        wait_n(4);
        lit("zero_frame_pos", int'(paddle_y), 0);
        lit("zero_frame_done", done_cnt - d0, 1);

        do_reset();
        pkt(1'b0, 1'b0, 8'd5);
        pkt(1'b0, 1'b0, 8'd7);
        tick();
        wait_n(4);
`ifdef PADDLE_DELTA_ACCUM_EN
        lit("two_pkts", int'(paddle_y), 196);
`else
        lit("two_pkts", int'(paddle_y), 201);
`endif

        do_reset();
        d0 = done_cnt;
        o0 = ovr_cnt;
        @(negedge clk);
        new_out = 1'b1; y_dir = 1'b0; y_max_speed = 1'b0; y_speed = 8'd4;
        frame_tick = 1'b1;
        @(negedge clk);
        new_out = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_n(4);
        lit("simul_pos", int'(paddle_y), 208);
        lit("simul_ovr_cnt", ovr_cnt - o0, 1);
        lit("simul_done_cnt", done_cnt - d0, 1);
        tick();
        wait_n(4);
        lit("simul_next_pos", int'(paddle_y), 204);

        do_reset();
        pkt(1'b0, 1'b0, 8'd10);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        reset_n = 1'b0;
        wait_n(2);
        d0 = done_cnt;
        reset_n = 1'b1;
        wait_n(5);
        lit("midreset_pos", int'(paddle_y), 208);
        lit("midreset_done", done_cnt - d0, 0);
        tick();
        wait_n(4);
        lit("midreset_after", int'(paddle_y), 208);

        wait_n(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
